vga_fb_arbiter: RTL and testbench

Shares one single-port, 1-cycle-latency framebuffer RAM between VGA scanout and a CPU-side requester, and double-buffers it. Sits between the VGA timing generator (consumes its `x`, `y`, `Vde`) and the pixel output path. Scanout reads a down-scaled framebuffer (one stored pixel per `SCALE`×`SCALE` screen block) and always has priority. The CPU port uses the remaining cycles and always targets the back buffer. A swap request flips front and back buffers at the next vertical-blank boundary.

---
 rtl/vga_fb_pkg.sv | 25 ++
 rtl/vga_fb_arbiter_tag_pipe.sv | 30 +++
 rtl/vga_fb_arbiter.sv | 138 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the VGA framebuffer arbiter.
// Tag encoding for the issue/return pipeline, swap FSM states and framebuffer size derivation.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_DISP   = 2'd1,
        TAG_CPU_RD = 2'd2,
        TAG_CPU_WR = 2'd3
    } tag_t;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    function automatic int fb_w(input int width, input int scale_shift);
        return width >> scale_shift;
    endfunction

    function automatic int fb_h(input int height, input int scale_shift);
        return height >> scale_shift;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_tag_pipe.sv
// Two-stage tag pipeline: stage 1 sits beside the RAM strobe, stage 2 beside the read data.
// Stage 2 decodes into the load enables for the pixel and CPU read-return registers.
module vga_fb_tag_pipe
    import vga_fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] issue_tag,
    output logic       disp_load,
    output logic       cpu_load
);

    tag_t issue_q;
    tag_t ret_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q <= TAG_NONE;
            ret_q   <= TAG_NONE;
        end else begin
            issue_q <= tag_t'(issue_tag);
            ret_q   <= issue_q;
        end
    end

    assign disp_load = (ret_q == TAG_DISP);
    assign cpu_load  = (ret_q == TAG_CPU_RD);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout fetch has priority, CPU uses idle slots on the back buffer.
// Front/back buffers swap at the start of vertical blanking after a swap request.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int H_B1        = 192,
    parameter int V_B1        = 41,
    parameter int SCALE_SHIFT = 3,
    parameter int DATA_W      = 12,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic              Vde,
    output logic [DATA_W-1:0] pix,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front
);

    localparam int          FB_W    = fb_w(WIDTH, SCALE_SHIFT);
    localparam logic [15:0] H_B1_W  = 16'(H_B1);
    localparam logic [15:0] V_B1_W  = 16'(V_B1);
    localparam logic [15:0] V_B2_W  = 16'(V_B1 + HEIGHT);
    localparam logic [15:0] WIDTH_W = 16'(WIDTH);

    logic [15:0]       fx;
    logic [15:0]       fy;
    logic              disp_fetch;
    logic              cpu_grant;
    logic              at_boundary;
    logic [ADDR_W-1:0] disp_index;
    tag_t              issue_tag;
    logic [ADDR_W:0]   next_addr;
    logic [DATA_W-1:0] next_wdata;
    logic              disp_load;
    logic              cpu_load;
    logic [DATA_W-1:0] pix_reg;
    swap_state_t       swap_state;

    // The +3 offset pre-compensates the three-cycle fetch-to-pixel latency.
    assign fx = x - H_B1_W + 16'd3;
    assign fy = y - V_B1_W;

    assign disp_fetch = (y >= V_B1_W) && (y < V_B2_W) && (fx < WIDTH_W)
                        && (fx[SCALE_SHIFT-1:0] == '0);
    assign disp_index = ADDR_W'((32'(fy >> SCALE_SHIFT) * FB_W) + 32'(fx >> SCALE_SHIFT));
    assign cpu_grant  = cpu_req && !disp_fetch && !cpu_ack;
    assign at_boundary = (y == V_B2_W) && (x == 16'd0);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves a latch.
    always_comb begin
        issue_tag  = TAG_NONE;
        next_addr  = '0;
        next_wdata = '0;
        if (disp_fetch) begin
            issue_tag = TAG_DISP;
            next_addr = {front, disp_index};
        end else if (cpu_grant) begin
            issue_tag = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            next_addr = {~front, cpu_addr};
            if (cpu_we) next_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            mem_en    <= (issue_tag != TAG_NONE);
            mem_we    <= (issue_tag == TAG_CPU_WR);
            mem_addr  <= next_addr;
            mem_wdata <= next_wdata;
            cpu_ack   <= cpu_grant;
        end
    end

    vga_fb_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue_tag (issue_tag),
        .disp_load (disp_load),
        .cpu_load  (cpu_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_reg    <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_load;
            if (disp_load) pix_reg <= mem_rdata;
            if (cpu_load) cpu_rdata <= mem_rdata;
        end
    end

    assign pix = Vde ? pix_reg : '0;

    // A request arriving exactly on the boundary swaps immediately without visiting PENDING.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_state <= SWAP_IDLE;
            front      <= 1'b0;
            swap_done  <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (at_boundary && (swap_state == SWAP_PENDING || swap_req)) begin
                front      <= ~front;
                swap_done  <= 1'b1;
                swap_state <= SWAP_IDLE;
            end else if (swap_req) begin
                swap_state <= SWAP_PENDING;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: table-driven fetch vectors, directed corner
// sequences and a scoreboard of expected RAM issues and CPU read returns.
module tb_vga_fb_arbiter;

    localparam int WIDTH       = 1920;
    localparam int HEIGHT      = 1080;
    localparam int H_B1        = 192;
    localparam int V_B1        = 41;
    localparam int SCALE_SHIFT = 3;
    localparam int DATA_W      = 12;
    localparam int ADDR_W      = 15;
    localparam int SCALE       = 1 << SCALE_SHIFT;
    localparam int FB_W        = WIDTH / SCALE;
    localparam int V_B2        = V_B1 + HEIGHT;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              vde;
    logic [DATA_W-1:0] pix;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              swap_req;
    logic              swap_done;
    logic              front;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .H_B1(H_B1), .V_B1(V_B1),
        .SCALE_SHIFT(SCALE_SHIFT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .Vde(vde), .pix(pix),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .swap_req(swap_req), .swap_done(swap_done),
        .front(front)
    );

    // Framebuffer RAM model, 1-cycle read latency; back half content differs from front half.
    logic [DATA_W-1:0] ram [0:(1<<(ADDR_W+1))-1];

    function automatic logic [DATA_W-1:0] ram_init(input logic [ADDR_W:0] a);
        return a[DATA_W-1:0] ^ (a[ADDR_W] ? 12'hF00 : 12'h000);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model state and scoreboards.
    typedef struct {
        logic              en;
        logic              we;
        logic [ADDR_W:0]   addr;
        logic [DATA_W-1:0] wdata;
        logic              ack;
        logic              front;
        logic              done;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    exp_t              issue_q[$];
    rd_t               rd_q[$];
    logic [DATA_W-1:0] shadow [int];
    logic              m_front = 1'b0;
    logic              m_pend  = 1'b0;
    logic              m_ack   = 1'b0;
    int                cyc     = 0;

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : ram_init(a);
    endfunction

    // One clock: predict from the current inputs, clock, then compare registered outputs.
    task automatic cycle();
        exp_t e;
        rd_t  r;
        int   sx;
        int   fyi;
        logic d;
        logic g;
        logic bnd;
        logic exp_rv;
        e.en = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0;
        e.ack = 1'b0; e.front = 1'b0; e.done = 1'b0;
        if (rst) begin
            m_front = 1'b0;
            m_pend  = 1'b0;
            m_ack   = 1'b0;
            rd_q.delete();
        end else begin
            sx  = int'(x) - H_B1 + 3;
            fyi = int'(y) - V_B1;
            d = (int'(y) >= V_B1) && (int'(y) < V_B2) && (sx >= 0) && (sx < WIDTH)
                && ((sx % SCALE) == 0);
            g = cpu_req && !d && !m_ack;
            if (d) begin
                e.en   = 1'b1;
                e.addr = {m_front, ADDR_W'((fyi / SCALE) * FB_W + sx / SCALE)};
            end else if (g) begin
                e.en    = 1'b1;
                e.we    = cpu_we;
                e.addr  = {~m_front, cpu_addr};
                e.wdata = cpu_we ? cpu_wdata : '0;
            end
            if (g) begin
                if (cpu_we) begin
                    shadow[int'({~m_front, cpu_addr})] = cpu_wdata;
                end else begin
                    r.data = exp_read({~m_front, cpu_addr});
                    r.due  = cyc + 2;
                    rd_q.push_back(r);
                end
            end
            e.ack = g;
            m_ack = g;
            bnd = (int'(y) == V_B2) && (x == 16'd0);
            if (bnd && (m_pend || swap_req)) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
                e.done  = 1'b1;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
            e.front = m_front;
        end
        issue_q.push_back(e);
        @(posedge clk);
        #1;
        e = issue_q.pop_front();
        check("mem_en", mem_en, e.en);
        if (e.en) check("mem_addr", mem_addr, e.addr);
        check("mem_we", mem_we, e.we);
        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        check("cpu_ack", cpu_ack, e.ack);
        check("front", front, e.front);
        check("swap_done", swap_done, e.done);
        exp_rv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        check("cpu_rvalid", cpu_rvalid, exp_rv);
        if (exp_rv) begin
            r = rd_q.pop_front();
            check("cpu_rdata", cpu_rdata, r.data);
        end
        cyc++;
    endtask

    typedef struct {
        logic [15:0]     x;
        logic [15:0]     y;
        logic            en;
        logic [ADDR_W:0] addr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        int disp_hits;
        int waits;
        int max_wait;
        logic req_active;
        logic [15:0] ys[6];

        for (int i = 0; i < (1 << (ADDR_W + 1)); i++) ram[i] = ram_init(ADDR_W'(i) | ((i >> ADDR_W) << ADDR_W));

        vecs[0]  = '{16'd189,  16'd41,   1'b1, 16'd0};
        vecs[1]  = '{16'd190,  16'd41,   1'b0, 16'd0};
        vecs[2]  = '{16'd197,  16'd41,   1'b1, 16'd1};
        vecs[3]  = '{16'd2101, 16'd41,   1'b1, 16'd239};
        vecs[4]  = '{16'd2109, 16'd41,   1'b0, 16'd0};
        vecs[5]  = '{16'd196,  16'd49,   1'b0, 16'd0};
        vecs[6]  = '{16'd189,  16'd49,   1'b1, 16'd240};
        vecs[7]  = '{16'd189,  16'd48,   1'b1, 16'd0};
        vecs[8]  = '{16'd189,  16'd40,   1'b0, 16'd0};
        vecs[9]  = '{16'd189,  16'd1120, 1'b1, 16'd32160};
        vecs[10] = '{16'd189,  16'd1121, 1'b0, 16'd0};
        vecs[11] = '{16'd188,  16'd41,   1'b0, 16'd0};
        vecs[12] = '{16'd2093, 16'd56,   1'b1, 16'd478};

        rst = 1'b1; x = '0; y = '0; vde = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; swap_req = 1'b0;

        // Reset state.
        cycle();
        cycle();
        vde = 1'b1;
        #1;
        check("reset_pix", pix, 0);
        check("reset_rdata", cpu_rdata, 0);
        vde = 1'b0;
        rst = 1'b0;

        // Fetch decisions and addresses from the table.
        for (int i = 0; i < 13; i++) begin
            x = vecs[i].x;
            y = vecs[i].y;
            cycle();
            check($sformatf("vec%0d_en", i), mem_en, vecs[i].en);
            if (vecs[i].en) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
        end

        // Scanout pixels along the start of line y=41 with RAM data = address.
        y = 16'd41;
        for (int xi = 185; xi <= 215; xi++) begin
            x = 16'(xi);
            vde = (xi >= H_B1);
            #1;
            check($sformatf("pix_x%0d", xi), pix, (xi < H_B1) ? 0 : (xi - H_B1) / SCALE);
            cycle();
        end
        vde = 1'b0;

        // CPU read held from x=188: granted before the D cycle at 189.
        x = 16'd188; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
        cycle();
        check("cpu_ack_at_189", cpu_ack, 1);
        check("cpu_rd_addr", mem_addr, 16'h8005);
        cpu_req = 1'b0;
        x = 16'd189;
        cycle();
        check("no_ack_at_190", cpu_ack, 0);
        check("disp_addr_190", mem_addr, 16'h0000);
        x = 16'd190;
        cycle();
        check("rvalid_2_after_ack", cpu_rvalid, 1);
        check("rdata_back_5", cpu_rdata, 12'hF05);

        // CPU write colliding with a D cycle waits one cycle.
        x = 16'd197; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd7; cpu_wdata = 12'hABC;
        cycle();
        check("wr_blocked_by_d", cpu_ack, 0);
        x = 16'd198;
        cycle();
        check("wr_ack", cpu_ack, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 16'h8007);
        check("wr_data", mem_wdata, 12'hABC);
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Continuous request in blanking: ack every second cycle, no display fetches.
        y = 16'd20; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd7;
        acks = 0; disp_hits = 0;
        for (int i = 0; i < 8; i++) begin
            x = 16'(500 + i);
            cycle();
            if (cpu_ack) acks++;
            if (mem_en && !mem_addr[ADDR_W]) disp_hits++;
        end
        cpu_req = 1'b0;
        check("blank_acks", acks, 4);
        check("blank_no_disp", disp_hits, 0);
        cycle();
        cycle();

        // Swap requested mid-frame takes effect at y=V_B2, x=0.
        y = 16'd500; x = 16'd1000; swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        check("swap_wait_front", front, 0);
        y = 16'd600; swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        y = 16'(V_B2); x = 16'd1;
        cycle();
        check("swap_not_yet", front, 0);
        x = 16'd0;
        cycle();
        check("swap_front", front, 1);
        check("swap_done_pulse", swap_done, 1);
        x = 16'd1;
        cycle();
        check("swap_done_once", swap_done, 0);
        x = 16'd0;
        cycle();
        check("no_second_swap", front, 1);
        y = 16'd41; x = 16'd189;
        cycle();
        check("next_frame_msb", mem_addr, 16'h8000);
        // Leave pix_reg holding the non-zero front-buffer word for the reset check.
        x = 16'd190;
        cycle();
        x = 16'd191;
        cycle();

        // Pending swap plus a read in flight, then reset.
        y = 16'd500; x = 16'd10; swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        y = 16'd20; x = 16'd100; cpu_req = 1'b1; cpu_addr = 15'd5;
        cycle();
        check("pre_rst_ack", cpu_ack, 1);
        check("pre_rst_addr", mem_addr, 16'h0005);
        cpu_req = 1'b0; rst = 1'b1; x = 16'd101;
        cycle();
        vde = 1'b1;
        #1;
        check("rst_pix", pix, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_front", front, 0);
        vde = 1'b0; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 16'(102 + i);
            cycle();
            check("no_rvalid_after_rst", cpu_rvalid, 0);
        end
        y = 16'(V_B2); x = 16'd0;
        cycle();
        check("pending_cleared", front, 0);
        check("pending_cleared_done", swap_done, 0);

        // Mixed traffic with a protocol-respecting CPU driver.
        ys[0] = 16'd40; ys[1] = 16'd41; ys[2] = 16'd48;
        ys[3] = 16'd49; ys[4] = 16'd1120; ys[5] = 16'd1121;
        req_active = 1'b0; waits = 0; max_wait = 0;
        for (int i = 0; i < 400; i++) begin
            y = ys[(i / 50) % 6];
            x = 16'((i < 200) ? 170 + i : 1900 + i);
            if (!req_active && !cpu_ack && ($urandom_range(0, 2) == 0)) begin
                req_active = 1'b1;
                cpu_req    = 1'b1;
                cpu_we     = 1'($urandom_range(0, 1));
                cpu_addr   = 15'($urandom_range(0, 31));
                cpu_wdata  = 12'($urandom);
                waits      = 0;
            end
            cycle();
            if (req_active) begin
                if (cpu_ack) begin
                    req_active = 1'b0;
                    cpu_req    = 1'b0;
                end else begin
                    waits++;
                    if (waits > max_wait) max_wait = waits;
                end
            end
        end
        cpu_req = 1'b0;
        check("max_cpu_wait_le1", max_wait <= 1, 1);
        for (int i = 0; i < 4; i++) cycle();
        check("rd_q_drained", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
